qmult_arbiter: RTL and testbench
================================

QMULT_ARBITER -- requirements
Module: qmult_arbiter

Interface
REQ-001 Parameter N, default 32, total operand/result width in bits (sign-magnitude, 1 sign bit + N-1 magnitude bits).
REQ-002 Parameter Q, default 15, number of fractional bits in operands and result.
REQ-003 Parameter NREQ, fixed at 4, number of requesters sharing the multiplier.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_req_valid  input  NREQ  per-requester operand-pair valid.
REQ-007 o_req_ready  output  NREQ  per-requester accept strobe; at most one bit high per cycle.
REQ-008 i_req_a  input  NREQ*N  multiplicands; requester k occupies bits [k*N+N-1:k*N].
REQ-009 i_req_b  input  NREQ*N  multipliers; same packing as i_req_a.
REQ-010 o_rsp_valid  output  1  response valid.
REQ-011 o_rsp_id  output  2  index of the requester that owns the response.
REQ-012 o_rsp_result  output  N  sign-magnitude Q-format product.
REQ-013 o_rsp_ovr  output  1  overflow flag for the product.
REQ-014 i_rsp_ready  input  1  response consumer ready.
REQ-015 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, MULT and HOLD; no other states.
REQ-017 In IDLE with any i_req_valid high, the block SHALL grant the first valid requester at or after the round-robin pointer (index order modulo 4), assert o_req_ready for that requester only in that same cycle (combinational from state, pointer and i_req_valid), latch its operands and id, and go to MULT.
REQ-018 o_req_ready SHALL be all-zero outside IDLE and in IDLE when no request is valid.
REQ-019 On each grant the pointer SHALL become (granted index + 1) mod 4.
REQ-020 In MULT the block SHALL register the product into the response registers and go to HOLD unconditionally.
REQ-021 Arithmetic: magnitude product P = a[N-2:0] * b[N-2:0] (2N-2 bits, unsigned); result[N-1] = a[N-1] XOR b[N-1]; result[N-2:0] = P[N-2+Q:Q]; ovr = 1 iff P[2N-3:N-1+Q] is nonzero; low Q bits truncated, no rounding, no saturation.
REQ-022 A zero magnitude with sign 1 SHALL be passed through unmodified (no negative-zero cleanup).
REQ-023 In HOLD, o_rsp_valid SHALL be high and o_rsp_id/o_rsp_result/o_rsp_ovr SHALL stay stable until i_rsp_ready is sampled high; on that edge the FSM returns to IDLE.
REQ-024 Latency: grant in cycle T SHALL produce o_rsp_valid in cycle T+2; minimum spacing between grants is 3 cycles.
REQ-025 No new grant SHALL occur in the cycle the response handshake completes; arbitration resumes the following cycle.
REQ-026 A requester dropping i_req_valid while not granted SHALL lose nothing and affect nothing; requests are not queued inside the block.
REQ-027 o_rsp_valid SHALL be low in IDLE and MULT.

Reset
REQ-028 With i_rst high at a rising edge: state IDLE, pointer 0, o_rsp_valid 0, o_rsp_id 0, o_rsp_result 0, o_rsp_ovr 0, o_busy 0.
REQ-029 Reset asserted during MULT or HOLD SHALL discard the in-flight operation with no response emitted.
REQ-030 While i_rst is high o_req_ready SHALL be all-zero.

Verification
REQ-031 Req0 a=0x0000C000 (1.5), b=0x00010000 (2.0) after reset -> o_req_ready=0001 at T, o_rsp_valid at T+2 with id 0, result 0x00018000, ovr 0.
REQ-032 Req2 a=0x80008000 (-1.0), b=0x00008000 (1.0) -> result 0x80008000, ovr 0, id 2.
REQ-033 Req1 a=0x40000000, b=0x00010000 -> result 0x00000000, ovr 1 (P bit 46 set).
REQ-034 All four valid continuously from reset, i_rsp_ready tied high -> grants in order 0,1,2,3,0, each 3 cycles apart, ids match.
REQ-035 i_rsp_ready held low 5 cycles in HOLD -> response fields constant, o_req_ready all-zero, o_busy 1; handshake then returns to IDLE with next grant one cycle later.
REQ-036 i_rst pulsed in the MULT cycle -> no o_rsp_valid, pointer back to 0, next grant goes to lowest valid index.

Source files
------------

// File: rtl/qmult_arbiter.sv
// qmult_arbiter
//   Four requesters share one sign-magnitude Q-format multiplier. A round-robin
//   arbiter grants one request at a time. The FSM then steps IDLE -> MULT -> HOLD.
//   The response is held in HOLD until the consumer accepts it.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid/a/b     per-requester operand pairs (requester k at [k*N +: N])
//   o_req_ready         one-hot accept strobe, IDLE only
//   o_rsp_valid/id/
//   o_rsp_result/ovr    response held until i_rsp_ready
//   i_rsp_ready         consumer ready
//   o_busy              FSM not in IDLE
module qmult_arbiter #(
  parameter int N    = 32,
  parameter int Q    = 15,
  parameter int NREQ = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*N-1:0] i_req_a,
  input  logic [NREQ*N-1:0] i_req_b,
  output logic              o_rsp_valid,
  output logic [1:0]        o_rsp_id,
  output logic [N-1:0]      o_rsp_result,
  output logic              o_rsp_ovr,
  input  logic              i_rsp_ready,
  output logic              o_busy
);

  localparam int PW = 2*N-2;

  typedef enum logic [1:0] {IDLE, MULT, HOLD} state_t;

  state_t         r_state, w_next;
  logic [1:0]     r_ptr;
  logic [N-1:0]   r_a, r_b;
  logic [1:0]     r_id;
  logic [N-1:0]   r_res;
  logic           r_ovr;
  logic [1:0]     r_rsp_id;

  logic           w_grant;
  logic [1:0]     w_gnt_id;
  logic [1:0]     w_idx;
  logic [PW-1:0]  w_prod;
  logic [N-1:0]   w_res;
  logic           w_ovr;

  // Round-robin pick: scan offsets from the highest down so that the smallest
  // offset from the pointer is the one left standing.
  always_comb begin
    w_grant  = 1'b0;
    w_gnt_id = 2'd0;
    w_idx    = 2'd0;
    for (int i = NREQ-1; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (i_req_valid[w_idx]) begin
        w_grant  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = '0;
    case (r_state)
      IDLE: if (w_grant && !i_rst) begin
        o_req_ready[w_gnt_id] = 1'b1;
        w_next                = MULT;
      end
      MULT: w_next = HOLD;
      HOLD: if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Magnitude product, truncated to Q fractional bits. Any bit above the result
  // magnitude raises ovr. Negative zero passes through unchanged.
  assign w_prod = PW'(r_a[N-2:0]) * PW'(r_b[N-2:0]);
  assign w_res  = {r_a[N-1] ^ r_b[N-1], w_prod[N-2+Q:Q]};
  assign w_ovr  = |w_prod[PW-1:N-1+Q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_ptr    <= 2'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= 2'd0;
      r_res    <= '0;
      r_ovr    <= 1'b0;
      r_rsp_id <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_grant) begin
        r_a   <= i_req_a[w_gnt_id*N +: N];
        r_b   <= i_req_b[w_gnt_id*N +: N];
        r_id  <= w_gnt_id;
        r_ptr <= w_gnt_id + 2'd1;
      end
      if (r_state == MULT) begin
        r_res    <= w_res;
        r_ovr    <= w_ovr;
        r_rsp_id <= r_id;
      end
    end
  end

  assign o_rsp_valid  = (r_state == HOLD);
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_res;
  assign o_rsp_ovr    = r_ovr;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_qmult_arbiter.sv
module tb_qmult_arbiter;

  localparam int N = 32;
  localparam int Q = 15;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [3:0]    i_req_valid;
  logic [3:0]    o_req_ready;
  logic [4*N-1:0] i_req_a, i_req_b;
  logic          o_rsp_valid;
  logic [1:0]    o_rsp_id;
  logic [N-1:0]  o_rsp_result;
  logic          o_rsp_ovr;
  logic          i_rsp_ready;
  logic          o_busy;

  int pass_cnt = 0;
  int total    = 0;

  qmult_arbiter #(.N(N), .Q(Q), .NREQ(4)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
    .o_rsp_result(o_rsp_result), .o_rsp_ovr(o_rsp_ovr),
    .i_rsp_ready(i_rsp_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One isolated transaction: grant at T, MULT at T+1, response at T+2.
  task automatic run_vec(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.id;
    @(negedge clk);
    i_req_valid = oh;
    i_req_a[v.id*N +: N] = v.a;
    i_req_b[v.id*N +: N] = v.b;
    #1 chk("vec_grant", 64'(o_req_ready), 64'(oh));
    @(negedge clk);
    i_req_valid = 4'b0;
    #1 chk("vec_mult_vld", 64'(o_rsp_valid), 64'd0);
    chk("vec_mult_busy", 64'(o_busy), 64'd1);
    @(negedge clk);
    #1 chk("vec_vld", 64'(o_rsp_valid), 64'd1);
    chk("vec_id", 64'(o_rsp_id), 64'(v.id));
    chk("vec_res", 64'(o_rsp_result), 64'(v.res));
    chk("vec_ovr", 64'(o_rsp_ovr), 64'(v.ovr));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    logic [31:0] hold_res;
    vecs[0] = '{0, 32'h0000C000, 32'h00010000, 32'h00018000, 1'b0}; // 1.5*2.0
    vecs[1] = '{2, 32'h80008000, 32'h00008000, 32'h80008000, 1'b0}; // -1*1
    vecs[2] = '{1, 32'h40000000, 32'h00010000, 32'h00000000, 1'b1}; // P bit 46
    vecs[3] = '{3, 32'h80000000, 32'h00008000, 32'h80000000, 1'b0}; // -0 kept
    vecs[4] = '{0, 32'h80010000, 32'h80018000, 32'h00030000, 1'b0}; // -2*-3
    vecs[5] = '{1, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0}; // truncated
    vecs[6] = '{2, 32'h7FFFFFFF, 32'h00008000, 32'h7FFFFFFF, 1'b0}; // max*1.0

    i_rst       = 1'b1;
    i_req_valid = 4'hF;
    i_req_a     = {32'h00030000, 32'h00020000, 32'h00010000, 32'h00008000};
    i_req_b     = {4{32'h00008000}};
    i_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("rst_ready", 64'(o_req_ready), 64'd0);
    chk("rst_vld", 64'(o_rsp_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_id", 64'(o_rsp_id), 64'd0);
    chk("rst_res", 64'(o_rsp_result), 64'd0);
    chk("rst_ovr", 64'(o_rsp_ovr), 64'd0);

    // All four valid continuously: grants 0,1,2,3,0 three cycles apart.
    @(negedge clk);
    i_rst = 1'b0;
    g = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (o_req_ready != 4'b0) begin
        chk("rr_order", 64'(o_req_ready), 64'(4'b0001 << (g % 4)));
        chk("rr_spacing", 64'(c), 64'(3*g));
        g++;
      end
      if (o_rsp_valid) chk("rr_id", 64'(o_rsp_id), 64'(((c-2)/3) % 4));
      @(negedge clk);
    end
    chk("rr_count", 64'(g), 64'd5);
    i_req_valid = 4'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-pressure: response held 5 cycles, no grants meanwhile.
    @(negedge clk);
    i_rsp_ready = 1'b0;
    i_req_valid = 4'b1000;
    i_req_a[3*N +: N] = 32'h00018000;
    i_req_b[3*N +: N] = 32'h80010000;
    hold_res = 32'h80030000;
    #1 chk("bp_grant", 64'(o_req_ready), 64'(4'b1000));
    @(negedge clk);
    i_req_valid = 4'b0010;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_vld", 64'(o_rsp_valid), 64'd1);
      chk("bp_id", 64'(o_rsp_id), 64'd3);
      chk("bp_res", 64'(o_rsp_result), 64'(hold_res));
      chk("bp_ovr", 64'(o_rsp_ovr), 64'd0);
      chk("bp_ready", 64'(o_req_ready), 64'd0);
      chk("bp_busy", 64'(o_busy), 64'd1);
      @(negedge clk);
    end
    i_rsp_ready = 1'b1;
    #1 chk("hs_vld", 64'(o_rsp_valid), 64'd1);
    chk("hs_nogrant", 64'(o_req_ready), 64'd0);
    @(negedge clk);
    #1 chk("hs_next_grant", 64'(o_req_ready), 64'(4'b0010));
    chk("hs_idle", 64'(o_busy), 64'd0);
    @(negedge clk);
    i_req_valid = 4'b0;
    repeat (3) @(negedge clk);

    // Reset during MULT: in-flight op discarded, pointer back to 0.
    i_req_valid = 4'b0100;
    #1 chk("rm_grant", 64'(o_req_ready), 64'(4'b0100));
    @(negedge clk);
    i_req_valid = 4'b0;
    i_rst = 1'b1;
    #1 chk("rm_mult_busy", 64'(o_busy), 64'd1);
    chk("rm_rst_ready", 64'(o_req_ready), 64'd0);
    @(negedge clk);
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("rm_no_vld", 64'(o_rsp_valid), 64'd0);
      chk("rm_busy", 64'(o_busy), 64'd0);
      @(negedge clk);
    end
    chk("rm_res", 64'(o_rsp_result), 64'd0);
    i_req_valid = 4'b1010;
    #1 chk("rm_ptr0_grant", 64'(o_req_ready), 64'(4'b0010));
    @(negedge clk);
    i_req_valid = 4'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
